updown_decoder: RTL

- Reader-side companion to the updown counter: samples a WIDTH-bit count bus every clock and classifies each step as up, down, hold or illegal.
- Tracks the current count direction with a small FSM and flags wrap-around events.
- Keeps a saturating error count of illegal jumps.
- Sits beside any updown counter instance as a run-time monitor and direction indicator for downstream logic.

---
 rtl/updown_decoder_pkg.sv | 28 ++
 rtl/updown_step_classify.sv | 42 ++++
 rtl/updown_decoder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/updown_decoder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : updown_decoder_pkg                                           |
// | Purpose : Shared types for the up/down count-bus decoder: FSM state    |
// |           encoding, step class encoding and the hold counter width.    |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package updown_decoder_pkg;

   localparam int unsigned HOLD_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_IDLE  = 2'd1,
      ST_UP    = 2'd2,
      ST_DOWN  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLS_HOLD    = 2'd0,
      CLS_UP      = 2'd1,
      CLS_DOWN    = 2'd2,
      CLS_ILLEGAL = 2'd3
   } step_cls_t;

endpackage
`default_nettype wire

// File: rtl/updown_step_classify.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : updown_step_classify                                         |
// | Purpose : Combinational classification of one count-bus step.          |
// | Ports   : prev      - previous sampled count                           |
// |           count_in  - current count                                    |
// |           cls       - HOLD / UP / DOWN / ILLEGAL                       |
// |           wrap_up   - all-ones -> 0 step                               |
// |           wrap_down - 0 -> all-ones step                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module updown_step_classify
   import updown_decoder_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] prev,
   input  logic [WIDTH-1:0] count_in,
   output step_cls_t        cls,
   output logic             wrap_up,
   output logic             wrap_down
);

   // Modular difference: +1 and -1 (all-ones) include the wrap cases.
   logic [WIDTH-1:0] delta;
   assign delta = count_in - prev;

   always_comb begin
      cls = CLS_ILLEGAL;
      if (delta == '0)
         cls = CLS_HOLD;
      else if (delta == WIDTH'(1))
         cls = CLS_UP;
      else if (delta == '1)
         cls = CLS_DOWN;
   end

   assign wrap_up   = (prev == '1) && (count_in == '0);
   assign wrap_down = (prev == '0) && (count_in == '1);

endmodule
`default_nettype wire

// File: rtl/updown_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : updown_decoder                                               |
// | Purpose : Run-time monitor for an up/down counter. Classifies each     |
// |           sampled step, tracks direction with an FSM, flags wraps and  |
// |           keeps a saturating count of illegal jumps.                   |
// | Ports   : clk, rst (async, active-low), count_in, en, clr_err          |
// |           dir_up, dir_down, idle         - direction levels           |
// |           step_up, step_down, wrap_up, wrap_down, illegal, dir_change  |
// |                                          - one-cycle pulses           |
// |           err_cnt                        - saturating illegal count   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module updown_decoder
   import updown_decoder_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned ERR_W    = 8,
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count_in,
   input  logic             en,
   input  logic             clr_err,
   output logic             dir_up,
   output logic             dir_down,
   output logic             idle,
   output logic             step_up,
   output logic             step_down,
   output logic             wrap_up,
   output logic             wrap_down,
   output logic             illegal,
   output logic             dir_change,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(HOLD_MAX);
   localparam logic [ERR_W-1:0]      ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};

   state_t                state;
   state_t                state_nxt;
   logic [WIDTH-1:0]      prev;
   logic [HOLD_CNT_W-1:0] hold_cnt;
   logic [HOLD_CNT_W-1:0] hold_nxt;
   logic [HOLD_CNT_W-1:0] hold_inc;
   logic [ERR_W-1:0]      err_base;
   logic [ERR_W-1:0]      err_nxt;
   logic                  dchg_nxt;
   logic                  classify;
   step_cls_t             cls;
   logic                  wu_c;
   logic                  wd_c;

   updown_step_classify #(
      .WIDTH (WIDTH)
   ) u_classify (
      .prev      (prev),
      .count_in  (count_in),
      .cls       (cls),
      .wrap_up   (wu_c),
      .wrap_down (wd_c)
   );

   // prev is meaningless while in PRIME, so nothing is classified there.
   assign classify = en && (state != ST_PRIME);
   assign hold_inc = hold_cnt + HOLD_CNT_W'(1);

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      dchg_nxt  = 1'b0;
      case (state)
         ST_PRIME: state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (cls == CLS_UP)
               state_nxt = ST_UP;
            else if (cls == CLS_DOWN)
               state_nxt = ST_DOWN;
         end
         ST_UP: begin
            case (cls)
               CLS_UP:      hold_nxt = '0;
               CLS_DOWN:    begin state_nxt = ST_DOWN; dchg_nxt = 1'b1; end
               CLS_ILLEGAL: state_nxt = ST_IDLE;
               default: begin
                  if (hold_inc == HOLD_LIMIT)
                     state_nxt = ST_IDLE;
                  else
                     hold_nxt = hold_inc;
               end
            endcase
         end
         default: begin  // ST_DOWN
            case (cls)
               CLS_DOWN:    hold_nxt = '0;
               CLS_UP:      begin state_nxt = ST_UP; dchg_nxt = 1'b1; end
               CLS_ILLEGAL: state_nxt = ST_IDLE;
               default: begin
                  if (hold_inc == HOLD_LIMIT)
                     state_nxt = ST_IDLE;
                  else
                     hold_nxt = hold_inc;
               end
            endcase
         end
      endcase
      if (state_nxt != state)
         hold_nxt = '0;
   end

   // Clear takes effect before the increment, so clear + illegal yields 1.
   always_comb begin
      err_base = clr_err ? '0 : err_cnt;
      err_nxt  = err_base;
      if (classify && (cls == CLS_ILLEGAL) && (err_base != '1))
         err_nxt = err_base + ERR_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_PRIME;
         prev       <= '0;
         hold_cnt   <= '0;
         err_cnt    <= '0;
         dir_up     <= 1'b0;
         dir_down   <= 1'b0;
         idle       <= 1'b1;
         step_up    <= 1'b0;
         step_down  <= 1'b0;
         wrap_up    <= 1'b0;
         wrap_down  <= 1'b0;
         illegal    <= 1'b0;
         dir_change <= 1'b0;
      end else begin
         err_cnt    <= err_nxt;
         step_up    <= classify && (cls == CLS_UP);
         step_down  <= classify && (cls == CLS_DOWN);
         wrap_up    <= classify && (cls == CLS_UP) && wu_c;
         wrap_down  <= classify && (cls == CLS_DOWN) && wd_c;
         illegal    <= classify && (cls == CLS_ILLEGAL);
         dir_change <= classify && dchg_nxt;
         if (en) begin
            prev     <= count_in;
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            dir_up   <= (state_nxt == ST_UP);
            dir_down <= (state_nxt == ST_DOWN);
            idle     <= (state_nxt == ST_IDLE) || (state_nxt == ST_PRIME);
         end else begin
            // A sampling gap invalidates prev; re-prime on the next sample.
            state    <= ST_PRIME;
            dir_up   <= 1'b0;
            dir_down <= 1'b0;
            idle     <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
